dual_vector_feeder: RTL and testbench

DUAL_VECTOR_FEEDER -- requirements
Module: dual_vector_feeder

---
 rtl/dual_vector_feeder.sv | 123 ++++++++++++
 tb/tb_dual_vector_feeder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_vector_feeder.sv
// Streams VECTOR_WIDTH element pairs from two internal memories, one pair per FETCH/PRESENT
// round trip, with valid/ready handshaking on the output side and a done pulse at the end.
module dual_vector_feeder #(
   parameter int DATA_WIDTH   = 8,
   parameter int VECTOR_WIDTH = 4,
   parameter int ADDR_WIDTH   = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  wr_sel,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_from_mem1,
   output logic [DATA_WIDTH-1:0] data_from_mem2,
   output logic                  data_valid,
   output logic                  last,
   output logic                  busy,
   output logic                  done
);

   localparam int Depth    = 1 << ADDR_WIDTH;
   localparam int CntWidth = $clog2(VECTOR_WIDTH) + 1;
   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(VECTOR_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StPresent, StDone} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
   logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
   logic                  rd_en;

   logic [DATA_WIDTH-1:0] mem1_q [Depth];
   logic [DATA_WIDTH-1:0] mem2_q [Depth];

   // Memory arrays are deliberately not reset so contents survive a mid-stream abort.
   always_ff @(posedge clk) begin
      if (wr_en && !wr_sel) begin
         mem1_q[wr_addr] <= wr_data;
      end
      if (wr_en && wr_sel) begin
         mem2_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      rd_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d  = base_addr;
               cnt_d   = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            rd_en   = 1'b1;
            state_d = StPresent;
         end
         StPresent: begin
            if (out_ready) begin
               if (cnt_q == LastCnt) begin
                  state_d = StDone;
               end else begin
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  cnt_d   = cnt_q + CntWidth'(1);
                  state_d = StFetch;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Read registers double as output holding registers; a read racing a write sees old data.
   always_comb begin
      rd1_d = rd1_q;
      rd2_d = rd2_q;
      if (rd_en) begin
         rd1_d = mem1_q[addr_q];
         rd2_d = mem2_q[addr_q];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         cnt_q   <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
      end
   end

   always_comb begin
      data_from_mem1 = rd1_q;
      data_from_mem2 = rd2_q;
      data_valid     = (state_q == StPresent);
      last           = (state_q == StPresent) && (cnt_q == LastCnt);
      busy           = (state_q != StIdle);
      done           = (state_q == StDone);
   end

endmodule

// File: tb/tb_dual_vector_feeder.sv
// Self-checking bench: table-driven vector runs against a memory model and an expected-pair
// queue, plus hand-written reset-abort and reset-state sequences.
module tb_dual_vector_feeder;

   localparam int DW = 8;
   localparam int VW = 4;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en, wr_sel, start, out_ready;
   logic [AW-1:0] wr_addr, base_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] data_from_mem1, data_from_mem2;
   logic          data_valid, last, busy, done;

   dual_vector_feeder #(
      .DATA_WIDTH  (DW),
      .VECTOR_WIDTH(VW),
      .ADDR_WIDTH  (AW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .wr_sel        (wr_sel),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .start         (start),
      .base_addr     (base_addr),
      .out_ready     (out_ready),
      .data_from_mem1(data_from_mem1),
      .data_from_mem2(data_from_mem2),
      .data_valid    (data_valid),
      .last          (last),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      logic          lst;
   } exp_t;

   typedef struct {
      logic [AW-1:0] base;
      int            stall_k;
      int            stall_n;
      bit            timing;
      bit            restart;
      bit            wr_fetch;
      logic [DW-1:0] exp_first_m1;
   } vec_t;

   exp_t          exp_q[$];
   logic [DW-1:0] mdl1 [1 << AW];
   logic [DW-1:0] mdl2 [1 << AW];
   int            tests = 0;
   int            fails = 0;

   function automatic void check(string name, int act, int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
      if (sel) mdl2[a] = d; else mdl1[a] = d;
   endtask

   task automatic run_vec(input vec_t v);
      int            cyc, acc, stalled, dones;
      logic [DW-1:0] h1, h2;
      logic [AW-1:0] a;
      exp_t          e;
      h1 = '0; h2 = '0;
      start = 1'b1; base_addr = v.base; out_ready = 1'b1;
      for (int k = 0; k < VW; k++) begin
         a = v.base + AW'(k);
         exp_q.push_back({mdl1[a], mdl2[a], k == VW - 1});
      end
      cyc = 0; acc = 0; stalled = 0; dones = 0;
      tick();
      cyc = 1;
      start = 1'b0;
      while (dones == 0 && cyc < 100) begin
         start     = v.restart && (cyc == 3);
         base_addr = v.restart ? v.base + AW'(5) : v.base;
         // Write to mem2 at the address being fetched this very cycle.
         wr_en = v.wr_fetch && (cyc == 1);
         wr_sel = 1'b1; wr_addr = v.base; wr_data = 8'h5A;
         if (data_valid) begin
            if (acc == v.stall_k && stalled < v.stall_n) begin
               if (stalled == 0) begin
                  h1 = data_from_mem1; h2 = data_from_mem2;
               end else begin
                  check("stall_hold_m1", data_from_mem1, h1);
                  check("stall_hold_m2", data_from_mem2, h2);
               end
               out_ready = 1'b0;
               stalled++;
            end else begin
               out_ready = 1'b1;
               if (exp_q.size() == 0) begin
                  check("unexpected_element", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("elem_m1", data_from_mem1, e.d1);
                  check("elem_m2", data_from_mem2, e.d2);
                  check("elem_last", last, e.lst);
                  if (acc == 0) check("first_m1_table", data_from_mem1, v.exp_first_m1);
               end
               if (v.timing) check("elem_cycle", cyc, 2 + 2 * acc);
               acc++;
            end
         end else begin
            out_ready = 1'b1;
            if (last) check("last_without_valid", last, 0);
         end
         if (done) begin
            dones++;
            if (v.timing) check("done_cycle", cyc, 2 * VW + 1);
         end
         tick();
         cyc++;
         if (v.wr_fetch && cyc == 2) mdl2[v.base] = 8'h5A;
      end
      wr_en = 1'b0; start = 1'b0;
      if (dones == 0) check("done_timeout", 0, 1);
      check("elem_count", acc, VW);
      check("queue_empty", exp_q.size(), 0);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
      tick();
      check("no_restart_busy", busy, 0);
      exp_q.delete();
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{base: 0,  stall_k: -1, stall_n: 0, timing: 1, restart: 0, wr_fetch: 0,
                 exp_first_m1: 8'd1};
      tbl[1] = '{base: 30, stall_k: -1, stall_n: 0, timing: 0, restart: 0, wr_fetch: 0,
                 exp_first_m1: 8'hA0};
      tbl[2] = '{base: 0,  stall_k: 1,  stall_n: 3, timing: 0, restart: 0, wr_fetch: 0,
                 exp_first_m1: 8'd1};
      tbl[3] = '{base: 0,  stall_k: -1, stall_n: 0, timing: 0, restart: 1, wr_fetch: 0,
                 exp_first_m1: 8'd1};
      tbl[4] = '{base: 4,  stall_k: -1, stall_n: 0, timing: 0, restart: 0, wr_fetch: 1,
                 exp_first_m1: 8'h14};
      tbl[5] = '{base: 4,  stall_k: 3,  stall_n: 2, timing: 0, restart: 0, wr_fetch: 0,
                 exp_first_m1: 8'h14};

      rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; base_addr = '0; out_ready = 1'b1;
      #1;
      check("rst_valid", data_valid, 0);
      check("rst_last", last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_m1", data_from_mem1, 0);
      check("rst_m2", data_from_mem2, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < (1 << AW); i++) begin
         wr(1'b0, AW'(i), DW'(8'h10 + i));
         wr(1'b1, AW'(i), DW'(8'h80 + i));
      end
      for (int i = 0; i < 4; i++) begin
         wr(1'b0, AW'(i), DW'(i + 1));
         wr(1'b1, AW'(i), DW'(i + 5));
      end
      wr(1'b0, AW'(30), 8'hA0);
      wr(1'b0, AW'(31), 8'hB0);
      check("idle_outputs_m1", data_from_mem1, 0);

      for (int t = 0; t < 6; t++) run_vec(tbl[t]);
      // New data written during the earlier fetch must show up now.
      check("collision_new_data", mdl2[4], 8'h5A);
      begin
         vec_t v;
         v = tbl[4];
         v.wr_fetch = 0;
         run_vec(v);
      end

      // Reset abort after element 1 has been accepted.
      start = 1'b1; base_addr = '0; out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 5; i++) tick();
      check("pre_abort_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("abort_valid", data_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_m1", data_from_mem1, 0);
      check("abort_m2", data_from_mem2, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_no_done", done, 0);
      end
      rst = 1'b0;
      begin
         vec_t v;
         v = '{base: 2, stall_k: -1, stall_n: 0, timing: 1, restart: 0, wr_fetch: 0,
               exp_first_m1: 8'd3};
         run_vec(v);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
